// File: rtl/spi_shift_engine_pkg.sv
// Shared definitions for the SPI shift engine: FSM state encoding and SPI mode codes {cpol,cpha}.
package spi_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // CPHA=0 modes capture MOSI on the edge that leaves the idle level.
  function automatic logic sample_on_leading(input logic [1:0] mode);
    case (mode)
      MODE0, MODE2: sample_on_leading = 1'b1;
      MODE1, MODE3: sample_on_leading = 1'b0;
      default:      sample_on_leading = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/spi_shift_engine_sync2.sv
// Two-flop synchroniser for one asynchronous pin, plus a flop holding the previous synchronised
// value so the consumer can detect transitions.
module spi_sync2
  import spi_defs::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic q_prev
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta   <= RESET_VAL;
      q      <= RESET_VAL;
      q_prev <= RESET_VAL;
    end else begin
      meta   <= d;
      q      <= meta;
      q_prev <= q;
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI peripheral-side shift engine: full duplex, WIDTH-bit frames, all four CPOL/CPHA modes,
// single-word TX holding buffer, frame-done / underrun / abort pulses.
module spi_shift_engine
  import spi_defs::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   LSB_FIRST = 1'b0,
  parameter logic IDLE_FILL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             sclk_in,
  input  logic             cs_n_in,
  input  logic             mosi_in,
  output logic             miso_out,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             frame_abort
);

  localparam int CW = $clog2(WIDTH + 1);

  logic sclk_s, sclk_p, cs_s, cs_p, mosi_s, mosi_prev_unused;

  spi_sync2 #(.RESET_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk_in), .q(sclk_s), .q_prev(sclk_p));
  spi_sync2 #(.RESET_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(cs_n_in), .q(cs_s),   .q_prev(cs_p));
  spi_sync2 #(.RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi_in), .q(mosi_s), .q_prev(mosi_prev_unused));

  state_t           state, next_state;
  logic             cpol_r, cpha_r;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg, tx_buf, shifted;
  logic             tx_full;
  logic             do_load, do_sample, do_shift, do_abort;
  logic             sclk_edge, lead_edge, trail_edge, sample_lead, sample_edge, shift_edge;
  logic             cs_fall, last_bit, tx_write;

  function automatic logic out_end(input logic [WIDTH-1:0] w);
    out_end = LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  assign sclk_edge   = sclk_s ^ sclk_p;
  assign lead_edge   = sclk_edge & (sclk_s != cpol_r);
  assign trail_edge  = sclk_edge & (sclk_s == cpol_r);
  assign sample_lead = sample_on_leading({cpol_r, cpha_r});
  assign sample_edge = sample_lead ? lead_edge : trail_edge;
  assign shift_edge  = sample_lead ? trail_edge : lead_edge;
  assign cs_fall     = cs_p & ~cs_s;
  assign last_bit    = (bit_cnt == CW'(WIDTH - 1));
  assign tx_write    = tx_valid & ~tx_full;
  // Capturing a bit pushes the already-presented bit out of the out end.
  assign shifted     = LSB_FIRST ? {mosi_s, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], mosi_s};

  assign miso_oe  = (state != IDLE);
  assign tx_ready = ~tx_full;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // In CPHA=0 the first bit is already presented by LOAD, so a shift edge before any sample is dropped.
  always_comb begin
    next_state = state;
    do_load    = 1'b0;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    do_abort   = 1'b0;
    case (state)
      IDLE: if (cs_fall) next_state = LOAD;
      LOAD: begin
        if (cs_s) next_state = IDLE;
        else begin
          do_load    = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          next_state = IDLE;
          do_abort   = (bit_cnt != '0);
        end else if (sample_edge) begin
          do_sample = 1'b1;
          if (last_bit) next_state = LOAD;
        end else if (shift_edge && (!sample_lead || bit_cnt != '0)) begin
          do_shift = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpol_r      <= 1'b0;
      cpha_r      <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      miso_out    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= do_abort;
      if (state == IDLE) begin
        cpol_r <= cpol;
        cpha_r <= cpha;
      end
      // A write landing in the LOAD cycle is kept for the next frame; LOAD only sees the old contents.
      tx_full <= (tx_full & ~do_load) | tx_write;
      if (tx_write) tx_buf <= tx_data;
      if (do_load) begin
        bit_cnt <= '0;
        if (tx_full) begin
          shreg    <= tx_buf;
          miso_out <= out_end(tx_buf);
        end else begin
          shreg       <= {WIDTH{IDLE_FILL}};
          miso_out    <= IDLE_FILL;
          tx_underrun <= 1'b1;
        end
      end
      if (do_sample) begin
        shreg <= shifted;
        if (last_bit) begin
          bit_cnt  <= '0;
          rx_data  <= shifted;
          rx_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
      if (do_shift) miso_out <= out_end(shreg);
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: an MSB-first and an LSB-first instance share one SPI master and are
// both checked against a word-level model of the TX buffer, frame loads and received words.
module tb_spi_shift_engine;

  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0, rst_n = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic [1:0] miso_out, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort;
  logic [W-1:0] rx_data [2];

  int errors = 0, checks = 0;
  int rxv_cnt [2] = '{0, 0};
  int und_cnt [2] = '{0, 0};
  int abt_cnt [2] = '{0, 0};

  bit buf_full = 1'b0;
  logic [W-1:0] buf_word = '0, cur_word = '0;
  logic [W-1:0] exp_rx [2] = '{8'h00, 8'h00};
  int exp_rxv = 0, exp_und = 0, exp_abt = 0;

  always #5 clk = ~clk;

  spi_shift_engine #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_FILL(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .sclk_in(sclk), .cs_n_in(cs_n),
    .mosi_in(mosi), .miso_out(miso_out[0]), .miso_oe(miso_oe[0]), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .tx_underrun(tx_underrun[0]), .frame_abort(frame_abort[0]));

  spi_shift_engine #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_FILL(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .sclk_in(sclk), .cs_n_in(cs_n),
    .mosi_in(mosi), .miso_out(miso_out[1]), .miso_oe(miso_oe[1]), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .tx_underrun(tx_underrun[1]), .frame_abort(frame_abort[1]));

  // Pulse counters; a one-cycle pulse adds exactly one.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rx_valid[k] === 1'b1)    rxv_cnt[k]++;
      if (tx_underrun[k] === 1'b1) und_cnt[k]++;
      if (frame_abort[k] === 1'b1) abt_cnt[k]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    for (int k = 0; k < 2; k++) begin
      check_output($sformatf("%s_rx_valid_count%0d", tag, k), rxv_cnt[k], exp_rxv);
      check_output($sformatf("%s_underrun_count%0d", tag, k), und_cnt[k], exp_und);
      check_output($sformatf("%s_abort_count%0d", tag, k), abt_cnt[k], exp_abt);
      check_output($sformatf("%s_rx_data%0d", tag, k), rx_data[k], exp_rx[k]);
    end
  endtask

  task automatic check_ready(input string tag);
    check_output(tag, tx_ready, {2{~buf_full}});
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_miso_out"}, miso_out, 2'b00);
    check_output({tag, "_miso_oe"}, miso_oe, 2'b00);
    check_output({tag, "_tx_ready"}, tx_ready, 2'b11);
    check_output({tag, "_rx_data0"}, rx_data[0], 8'h00);
    check_output({tag, "_rx_data1"}, rx_data[1], 8'h00);
    check_output({tag, "_pulses"}, {rx_valid, tx_underrun, frame_abort}, 6'd0);
  endtask

  // Every frame load takes the buffered word, or an all-fill word with an underrun.
  task automatic model_load();
    if (buf_full) begin
      cur_word = buf_word;
      buf_full = 1'b0;
    end else begin
      cur_word = '1;
      exp_und++;
    end
  endtask

  task automatic write_tx(input logic [W-1:0] word);
    int n = 0;
    while (tx_ready !== 2'b11 && n < 50) begin
      tick(1);
      n++;
    end
    check_output("tx_ready_before_write", tx_ready, 2'b11);
    tx_data  = word;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    buf_full = 1'b1;
    buf_word = word;
  endtask

  task automatic start_frame(input logic [1:0] mode);
    cpol = mode[1];
    cpha = mode[0];
    sclk = mode[1];
    tick(6);
    cs_n = 1'b0;
    tick(8);
    model_load();
    check_output("miso_oe_in_frame", miso_oe, 2'b11);
  endtask

  // seq[i] is the i-th bit on the wire; the master checks miso just before each sample edge.
  task automatic apply_stimulus(input logic [W-1:0] seq, input int nbits);
    logic [W-1:0] e0, e1;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = seq[i];
        tick(H);
        check_output($sformatf("miso_bit%0d", i), miso_out, {cur_word[i], cur_word[W-1-i]});
        sclk = ~cpol;
        tick(H);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = seq[i];
        tick(H);
        check_output($sformatf("miso_bit%0d", i), miso_out, {cur_word[i], cur_word[W-1-i]});
        sclk = cpol;
        tick(H);
      end
    end
    if (nbits == W) begin
      tick(H);
      e0 = '0;
      e1 = '0;
      for (int i = 0; i < W; i++) begin
        e0    = {e0[W-2:0], seq[i]};
        e1[i] = seq[i];
      end
      exp_rx[0] = e0;
      exp_rx[1] = e1;
      exp_rxv++;
      model_load();
      check_counts("frame_done");
    end
  endtask

  task automatic end_frame();
    cs_n = 1'b1;
    sclk = cpol;
    tick(8);
    check_output("miso_oe_after_cs", miso_oe, 2'b00);
    check_counts("frame_end");
  endtask

  initial begin
    rst_n = 1'b0;
    tick(4);
    check_reset_values("reset");
    rst_n = 1'b1;
    tick(4);

    $display("[TB] mode 0, tx A5, master 3C");
    write_tx(8'hA5);
    start_frame(2'b00);
    apply_stimulus(8'b0011_1100, W);
    end_frame();

    $display("[TB] mode 3, tx 81, mosi F0 lsb-first");
    write_tx(8'h81);
    start_frame(2'b11);
    apply_stimulus(8'hF0, W);
    end_frame();

    $display("[TB] underrun frame");
    start_frame(2'b01);
    check_counts("underrun_start");
    apply_stimulus(W'($urandom), W);
    end_frame();

    $display("[TB] abort after 3 bits");
    write_tx(8'h5A);
    start_frame(2'b10);
    apply_stimulus(W'($urandom), 3);
    exp_abt++;
    end_frame();

    $display("[TB] back-to-back frames");
    write_tx(8'h11);
    start_frame(2'b01);
    check_ready("ready_after_first_load");
    write_tx(8'h22);
    check_ready("ready_low_while_buffered");
    apply_stimulus(W'($urandom), W);
    check_ready("ready_after_second_load");
    apply_stimulus(W'($urandom), W);
    end_frame();

    $display("[TB] reset mid-frame");
    write_tx(8'hC3);
    start_frame(2'b00);
    write_tx(8'h3C);
    apply_stimulus(W'($urandom), 4);
    rst_n = 1'b0;
    tick(1);
    check_reset_values("reset_mid_frame");
    tick(2);
    cs_n = 1'b1;
    sclk = cpol;
    rst_n = 1'b1;
    buf_full = 1'b0;
    exp_rx[0] = '0;
    exp_rx[1] = '0;
    tick(6);
    check_counts("after_reset");

    $display("[TB] random frames");
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 1) == 1) write_tx(W'($urandom));
      start_frame(2'($urandom_range(0, 3)));
      apply_stimulus(W'($urandom), W);
      end_frame();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
